// File: rtl/pulse_sync_pkg.sv
// Shared constants, priming FSM state type and edge-detect helper for the
// multi-channel pulse synchroniser receiver.
package pulse_sync_pkg;

  localparam int EDGE_ANY  = 0;
  localparam int EDGE_RISE = 1;
  localparam int EDGE_FALL = 2;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int PRIME_CNT_W     = 3;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } prime_state_e;

  function automatic logic detect_edge(input int mode, input logic s, input logic h);
    case (mode)
      EDGE_RISE: return s & ~h;
      EDGE_FALL: return ~s & h;
      default:   return s ^ h;
    endcase
  endfunction

endpackage

// File: rtl/pulse_sync_ch.sv
// One receive channel: synchroniser chain, edge history, event detect,
// saturating pending counter with valid/ready drain and sticky overflow flag.
module pulse_sync_ch
  import pulse_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter int EDGE_MODE   = EDGE_ANY
) (
  input  logic             clk_dst,
  input  logic             rst,
  input  logic             run_en,
  input  logic             async_in,
  input  logic             ev_ready,
  input  logic             ovf_clr,
  output logic             ev_pulse,
  output logic             ev_valid,
  output logic [CNT_W-1:0] ev_count,
  output logic             ev_overflow
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_pulse;
  logic [CNT_W-1:0]       r_count;
  logic                   r_ovf;

  logic w_s;
  logic w_inc;
  logic w_dec;
  logic w_full;
  logic w_lost;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_inc  = run_en & detect_edge(EDGE_MODE, w_s, r_hist);
  assign w_dec  = ev_valid & ev_ready;
  assign w_full = &r_count;
  // An event is only lost when the counter is full and nothing drains this cycle.
  assign w_lost = w_inc & ~w_dec & w_full;

  always_ff @(posedge clk_dst) begin
    if (rst) begin
      r_sync  <= '0;
      r_hist  <= 1'b0;
      r_pulse <= 1'b0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_hist  <= w_s;
      r_pulse <= w_inc;
      if (w_inc && !w_dec && !w_full) begin
        r_count <= r_count + 1'b1;
      end else if (w_dec && !w_inc) begin
        r_count <= r_count - 1'b1;
      end
      if (w_lost) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign ev_pulse    = r_pulse;
  assign ev_valid    = |r_count;
  assign ev_count    = r_count;
  assign ev_overflow = r_ovf;

endmodule

// File: rtl/pulse_sync_rx_multi.sv
// Multi-channel cross-clock event receiver: shared post-reset priming FSM and
// per-channel synchronisers. Optional irq output enabled by PULSE_SYNC_RX_IRQ_EN.
module pulse_sync_rx_multi
  import pulse_sync_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter int EDGE_MODE   = EDGE_ANY
) (
  input  logic                    clk_dst,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       async_in,
  output logic [NUM_CH-1:0]       ev_pulse,
  output logic [NUM_CH-1:0]       ev_valid,
  input  logic [NUM_CH-1:0]       ev_ready,
  output logic [NUM_CH*CNT_W-1:0] ev_count,
  output logic [NUM_CH-1:0]       ev_overflow,
  input  logic [NUM_CH-1:0]       ovf_clr,
  output logic                    primed
`ifdef PULSE_SYNC_RX_IRQ_EN
  ,
  input  logic [NUM_CH-1:0]       irq_mask,
  output logic                    irq
`endif
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX ||
      NUM_CH < 1 || NUM_CH > 32 || CNT_W < 1 || CNT_W > 8 ||
      EDGE_MODE < EDGE_ANY || EDGE_MODE > EDGE_FALL) begin : g_bad_cfg
    $error("pulse_sync_rx_multi: parameter out of range");
  end

  localparam logic [PRIME_CNT_W-1:0] PRIME_LAST = PRIME_CNT_W'(SYNC_STAGES);

  prime_state_e           r_state;
  prime_state_e           w_state_nxt;
  logic [PRIME_CNT_W-1:0] r_prime_cnt;
  logic [PRIME_CNT_W-1:0] w_prime_cnt_nxt;
  logic                   w_run_en;

  always_ff @(posedge clk_dst) begin
    if (rst) begin
      r_state     <= PRIME;
      r_prime_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_prime_cnt <= w_prime_cnt_nxt;
    end
  end

  // Stay in PRIME for SYNC_STAGES+1 cycles so chains and edge history settle.
  always_comb begin
    w_state_nxt     = r_state;
    w_prime_cnt_nxt = r_prime_cnt;
    case (r_state)
      PRIME: begin
        if (r_prime_cnt == PRIME_LAST) begin
          w_state_nxt = RUN;
        end else begin
          w_prime_cnt_nxt = r_prime_cnt + 1'b1;
        end
      end
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = PRIME;
    endcase
  end

  assign w_run_en = (r_state == RUN);
  assign primed   = w_run_en;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pulse_sync_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W),
      .EDGE_MODE  (EDGE_MODE)
    ) u_ch (
      .clk_dst    (clk_dst),
      .rst        (rst),
      .run_en     (w_run_en),
      .async_in   (async_in[i]),
      .ev_ready   (ev_ready[i]),
      .ovf_clr    (ovf_clr[i]),
      .ev_pulse   (ev_pulse[i]),
      .ev_valid   (ev_valid[i]),
      .ev_count   (ev_count[i*CNT_W +: CNT_W]),
      .ev_overflow(ev_overflow[i])
    );
  end

`ifdef PULSE_SYNC_RX_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk_dst) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |((ev_valid | ev_overflow) & irq_mask);
    end
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_pulse_sync_rx_multi.sv
// Scoreboard bench for pulse_sync_rx_multi: expected strobes are queued at each
// input toggle and popped when ev_pulse fires; mode 1/2 instances check edge selection.
module tb_pulse_sync_rx_multi;

  localparam int NUM_CH = 4;
  localparam int SS     = 2;
  localparam int CW     = 4;

  logic clk_dst = 1'b0;
  always #5 clk_dst = ~clk_dst;

  logic                 rst;
  logic [NUM_CH-1:0]    async_in, ev_ready, ovf_clr;
  logic [NUM_CH-1:0]    ev_pulse, ev_valid, ev_overflow;
  logic [NUM_CH*CW-1:0] ev_count;
  logic                 primed;
  logic [NUM_CH-1:0]    rise_pulse, rise_valid, rise_ovf;
  logic [NUM_CH*CW-1:0] rise_count;
  logic                 rise_primed;
  logic [NUM_CH-1:0]    fall_pulse, fall_valid, fall_ovf;
  logic [NUM_CH*CW-1:0] fall_count;
  logic                 fall_primed;
`ifdef PULSE_SYNC_RX_IRQ_EN
  logic [NUM_CH-1:0]    irq_mask;
  logic                 irq, rise_irq, fall_irq;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int lat0  = 3;

  pulse_sync_rx_multi #(.NUM_CH(NUM_CH), .SYNC_STAGES(SS), .CNT_W(CW), .EDGE_MODE(0)) dut (
    .clk_dst(clk_dst), .rst(rst), .async_in(async_in), .ev_pulse(ev_pulse),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_count(ev_count),
    .ev_overflow(ev_overflow), .ovf_clr(ovf_clr), .primed(primed)
`ifdef PULSE_SYNC_RX_IRQ_EN
    , .irq_mask(irq_mask), .irq(irq)
`endif
  );

  pulse_sync_rx_multi #(.NUM_CH(NUM_CH), .SYNC_STAGES(SS), .CNT_W(CW), .EDGE_MODE(1)) dut_rise (
    .clk_dst(clk_dst), .rst(rst), .async_in(async_in), .ev_pulse(rise_pulse),
    .ev_valid(rise_valid), .ev_ready(4'b0000), .ev_count(rise_count),
    .ev_overflow(rise_ovf), .ovf_clr(4'b0000), .primed(rise_primed)
`ifdef PULSE_SYNC_RX_IRQ_EN
    , .irq_mask(4'b0000), .irq(rise_irq)
`endif
  );

  pulse_sync_rx_multi #(.NUM_CH(NUM_CH), .SYNC_STAGES(SS), .CNT_W(CW), .EDGE_MODE(2)) dut_fall (
    .clk_dst(clk_dst), .rst(rst), .async_in(async_in), .ev_pulse(fall_pulse),
    .ev_valid(fall_valid), .ev_ready(4'b0000), .ev_count(fall_count),
    .ev_overflow(fall_ovf), .ovf_clr(4'b0000), .primed(fall_primed)
`ifdef PULSE_SYNC_RX_IRQ_EN
    , .irq_mask(4'b0000), .irq(fall_irq)
`endif
  );

  task automatic cyc();
    @(posedge clk_dst);
    #1;
  endtask

  task automatic toggle(input int ch);
    async_in[ch] = ~async_in[ch];
    exp_q.push_back(1 << ch);
  endtask

  task automatic test_reset();
    rst = 1'b1; async_in = 4'b0101; ev_ready = '0; ovf_clr = '0;
`ifdef PULSE_SYNC_RX_IRQ_EN
    irq_mask = '0;
`endif
    repeat (3) cyc();
    n_cmp++;
    if ({ev_pulse, ev_valid, ev_overflow} !== 12'h000) begin
      n_bad++; $display("FAIL reset_flags got=%h want=000", {ev_pulse, ev_valid, ev_overflow});
    end
    n_cmp++;
    if (ev_count !== 16'h0000) begin
      n_bad++; $display("FAIL reset_count got=%h want=0000", ev_count);
    end
    n_cmp++;
    if (primed !== 1'b0) begin
      n_bad++; $display("FAIL reset_primed got=%b want=0", primed);
    end
    rst = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      n_cmp++;
      if (primed !== ((c >= 3) ? 1'b1 : 1'b0)) begin
        n_bad++; $display("FAIL prime_cycle%0d got=%b want=%b", c, primed, (c >= 3));
      end
      n_cmp++;
      if (ev_pulse !== 4'b0000 || ev_count !== 16'h0 || rise_count !== 16'h0 || fall_count !== 16'h0) begin
        n_bad++; $display("FAIL prime_spurious cycle%0d pulse=%b cnt=%h rise=%h fall=%h want 0",
                          c, ev_pulse, ev_count, rise_count, fall_count);
      end
    end
  endtask

  task automatic test_single_toggle();
    int e;
    toggle(0);
    lat0 = 0;
    for (int c = 1; c <= 5 && lat0 == 0; c++) begin
      cyc();
      if (ev_pulse !== 4'b0000) begin
        lat0 = c;
        e = exp_q.pop_front();
        n_cmp++;
        if (ev_pulse !== 4'(e)) begin
          n_bad++; $display("FAIL single_pulse got=%b want=%b", ev_pulse, 4'(e));
        end
      end
    end
    n_cmp++;
    if (lat0 < SS || lat0 > SS + 1) begin
      n_bad++; $display("FAIL single_latency got=%0d want=%0d..%0d", lat0, SS, SS + 1);
      lat0 = SS + 1;
    end
    cyc();
    n_cmp++;
    if (ev_pulse !== 4'b0000) begin
      n_bad++; $display("FAIL single_width got=%b want=0000", ev_pulse);
    end
    n_cmp++;
    if (ev_count[3:0] !== 4'd1 || ev_valid !== 4'b0001) begin
      n_bad++; $display("FAIL single_count got=%0d valid=%b want=1 valid=0001", ev_count[3:0], ev_valid);
    end
    ev_ready[0] = 1'b1;
    cyc();
    ev_ready[0] = 1'b0;
    n_cmp++;
    if (ev_count[3:0] !== 4'd0 || ev_valid[0] !== 1'b0) begin
      n_bad++; $display("FAIL single_drain got=%0d valid=%b want=0", ev_count[3:0], ev_valid[0]);
    end
  endtask

  task automatic test_overflow();
    int e, seen;
    for (int j = 1; j <= 17; j++) begin
      toggle(1);
      seen = 0;
      for (int c = 0; c < 4; c++) begin
        cyc();
        if (ev_pulse !== 4'b0000) begin
          seen++;
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
          n_cmp++;
          if (ev_pulse !== 4'(e)) begin
            n_bad++; $display("FAIL ovf_pulse ev%0d got=%b want=%b", j, ev_pulse, 4'(e));
          end
        end
      end
      n_cmp++;
      if (seen != 1 || ev_count[7:4] !== 4'((j > 15) ? 15 : j) || ev_overflow[1] !== ((j >= 16) ? 1'b1 : 1'b0)) begin
        n_bad++; $display("FAIL ovf_count ev%0d pulses=%0d cnt=%0d ovf=%b want 1/%0d/%b",
                          j, seen, ev_count[7:4], ev_overflow[1], (j > 15) ? 15 : j, (j >= 16));
      end
    end
    ovf_clr[1] = 1'b1;
    cyc();
    ovf_clr[1] = 1'b0;
    n_cmp++;
    if (ev_overflow[1] !== 1'b0) begin
      n_bad++; $display("FAIL ovf_clear got=%b want=0", ev_overflow[1]);
    end
    toggle(1);
    ovf_clr[1] = 1'b1;
    seen = 0;
    for (int c = 0; c < 5 && seen == 0; c++) begin
      cyc();
      if (ev_pulse !== 4'b0000) begin
        seen = 1;
        e = exp_q.pop_front();
        n_cmp++;
        if (ev_pulse !== 4'(e)) begin
          n_bad++; $display("FAIL ovf_setwin_pulse got=%b want=%b", ev_pulse, 4'(e));
        end
      end
    end
    ovf_clr[1] = 1'b0;
    n_cmp++;
    if (seen != 1 || ev_overflow[1] !== 1'b1 || ev_count[7:4] !== 4'd15) begin
      n_bad++; $display("FAIL ovf_set_wins seen=%0d ovf=%b cnt=%0d want 1/1/15", seen, ev_overflow[1], ev_count[7:4]);
    end
    repeat (3) cyc();
  endtask

  task automatic test_full_simul();
    int e, seen;
    for (int j = 1; j <= 15; j++) begin
      toggle(2);
      seen = 0;
      for (int c = 0; c < 4; c++) begin
        cyc();
        if (ev_pulse !== 4'b0000) begin
          seen++;
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
          n_cmp++;
          if (ev_pulse !== 4'(e)) begin
            n_bad++; $display("FAIL fill_pulse ev%0d got=%b want=%b", j, ev_pulse, 4'(e));
          end
        end
      end
      n_cmp++;
      if (seen != 1) begin
        n_bad++; $display("FAIL fill_seen ev%0d got=%0d want=1", j, seen);
      end
    end
    n_cmp++;
    if (ev_count[11:8] !== 4'd15 || ev_overflow[2] !== 1'b0) begin
      n_bad++; $display("FAIL fill_full cnt=%0d ovf=%b want 15/0", ev_count[11:8], ev_overflow[2]);
    end
    toggle(2);
    repeat (lat0 - 1) cyc();
    ev_ready[2] = 1'b1;
    cyc();
    ev_ready[2] = 1'b0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
    n_cmp++;
    if (ev_pulse !== 4'(e) || ev_count[11:8] !== 4'd15 || ev_overflow[2] !== 1'b0) begin
      n_bad++; $display("FAIL full_inc_dec pulse=%b cnt=%0d ovf=%b want %b/15/0",
                        ev_pulse, ev_count[11:8], ev_overflow[2], 4'(e));
    end
    repeat (3) cyc();
  endtask

  task automatic test_edge_mode();
    int e, seen, rp, fp;
    for (int ph = 0; ph < 2; ph++) begin
      toggle(3);
      seen = 0; rp = 0; fp = 0;
      for (int c = 0; c < 4; c++) begin
        cyc();
        if (rise_pulse[3] === 1'b1) rp++;
        if (fall_pulse[3] === 1'b1) fp++;
        if (ev_pulse !== 4'b0000) begin
          seen++;
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
          n_cmp++;
          if (ev_pulse !== 4'(e)) begin
            n_bad++; $display("FAIL mode0_pulse ph%0d got=%b want=%b", ph, ev_pulse, 4'(e));
          end
        end
      end
      n_cmp++;
      if (rp != ((ph == 0) ? 1 : 0) || fp != ((ph == 0) ? 0 : 1) || seen != 1) begin
        n_bad++; $display("FAIL edge_strobes ph%0d rise=%0d fall=%0d any=%0d want %0d/%0d/1",
                          ph, rp, fp, seen, (ph == 0) ? 1 : 0, (ph == 0) ? 0 : 1);
      end
      n_cmp++;
      if (rise_count[15:12] !== 4'd1 || fall_count[15:12] !== 4'(ph) || ev_count[15:12] !== 4'(ph + 1)) begin
        n_bad++; $display("FAIL edge_counts ph%0d rise=%0d fall=%0d any=%0d want 1/%0d/%0d",
                          ph, rise_count[15:12], fall_count[15:12], ev_count[15:12], ph, ph + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int e, seen;
    for (int j = 1; j <= 7; j++) begin
      toggle(0);
      seen = 0;
      for (int c = 0; c < 4; c++) begin
        cyc();
        if (ev_pulse !== 4'b0000) begin
          seen++;
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
          n_cmp++;
          if (ev_pulse !== 4'(e)) begin
            n_bad++; $display("FAIL mid_pulse ev%0d got=%b want=%b", j, ev_pulse, 4'(e));
          end
        end
      end
    end
    n_cmp++;
    if (ev_count[3:0] !== 4'd7) begin
      n_bad++; $display("FAIL mid_count7 got=%0d want=7", ev_count[3:0]);
    end
    rst = 1'b1;
    cyc();
    n_cmp++;
    if (ev_count !== 16'h0 || ev_valid !== 4'b0 || primed !== 1'b0 || ev_overflow !== 4'b0) begin
      n_bad++; $display("FAIL mid_reset cnt=%h valid=%b primed=%b ovf=%b want 0", ev_count, ev_valid, primed, ev_overflow);
    end
    rst = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      n_cmp++;
      if (primed !== ((c >= 3) ? 1'b1 : 1'b0) || ev_pulse !== 4'b0 || ev_count !== 16'h0) begin
        n_bad++; $display("FAIL mid_reprime cycle%0d primed=%b pulse=%b cnt=%h", c, primed, ev_pulse, ev_count);
      end
    end
  endtask

`ifdef PULSE_SYNC_RX_IRQ_EN
  task automatic test_irq();
    int e, found;
    irq_mask = 4'b0001;
    cyc();
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++; $display("FAIL irq_idle got=%b want=0", irq);
    end
    toggle(0);
    found = 0;
    for (int c = 0; c < 6 && found == 0; c++) begin
      cyc();
      if (ev_pulse !== 4'b0000) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
        n_cmp++;
        if (ev_pulse !== 4'(e)) begin
          n_bad++; $display("FAIL irq_pulse got=%b want=%b", ev_pulse, 4'(e));
        end
      end
      if (ev_valid[0] === 1'b1) begin
        found = 1;
        n_cmp++;
        if (irq !== 1'b0) begin
          n_bad++; $display("FAIL irq_early got=%b want=0", irq);
        end
        cyc();
        n_cmp++;
        if (irq !== 1'b1) begin
          n_bad++; $display("FAIL irq_late got=%b want=1", irq);
        end
      end
    end
    n_cmp++;
    if (found != 1) begin
      n_bad++; $display("FAIL irq_valid_timeout got=%0d want=1", found);
    end
    ev_ready[0] = 1'b1;
    cyc();
    ev_ready[0] = 1'b0;
    cyc();
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++; $display("FAIL irq_drop got=%b want=0", irq);
    end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_toggle();
    test_overflow();
    test_full_simul();
    test_edge_mode();
    test_reset_mid();
`ifdef PULSE_SYNC_RX_IRQ_EN
    test_irq();
`endif
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
